// File: rtl/load_store_unit_pkg.sv
// Shared funct3 encodings and byte-lane helpers for the load/store unit.
// Store lane steering and access legality are kept here so the top and align logic agree.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Illegal encodings and misaligned halfword/word accesses never reach the bus.
    function automatic logic access_fault(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = rd && wr;
        if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) bad = 1'b1;
        if (wr && (f3 > F3_SW)) bad = 1'b1;
        if (f3[1:0] == 2'd1 && off[0]) bad = 1'b1;
        if (f3[1:0] == 2'd2 && off != 2'd0) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: selects the addressed lane of a read word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
    import load_store_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       offset,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] lane;

    always_comb begin
        lane  = rdata >> {offset, 3'b000};
        value = rdata;
        case (funct3)
            F3_LB:   value = {{(WIDTH-8){lane[7]}}, lane[7:0]};
            F3_LBU:  value = {{(WIDTH-8){1'b0}}, lane[7:0]};
            F3_LH:   value = {{(WIDTH-16){lane[15]}}, lane[15:0]};
            F3_LHU:  value = {{(WIDTH-16){1'b0}}, lane[15:0]};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM stage: issues word-aligned data-memory requests for loads/stores, aligns
// load data, and returns one registered writeback pulse per accepted instruction.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [WIDTH-1:0] ex_alu_out,
    input  logic [WIDTH-1:0] ex_store_data,
    input  logic [2:0]       ex_funct3,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_reg_write,
    output logic             wb_fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] addr_reg;
    logic [2:0]       funct3_reg;
    logic [4:0]       rd_reg;
    logic             reg_write_reg;
    logic             we_reg;
    logic [WIDTH-1:0] dmem_addr_reg, dmem_wdata_reg;
    logic [3:0]       dmem_be_reg;
    logic             wb_valid_reg, wb_reg_write_reg, wb_fault_reg;
    logic [4:0]       wb_rd_reg;
    logic [WIDTH-1:0] wb_data_reg;
    logic [WIDTH-1:0] load_value;

    logic accept, is_mem, fault;

    assign accept = ex_valid && (state_reg == S_IDLE);
    assign is_mem = ex_mem_read || ex_mem_write;
    assign fault  = is_mem && access_fault(ex_mem_read, ex_mem_write, ex_funct3, ex_alu_out[1:0]);

    lsu_load_align #(.WIDTH(WIDTH)) u_align (
        .rdata  (dmem_rdata),
        .offset (addr_reg[1:0]),
        .funct3 (funct3_reg),
        .value  (load_value)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept && is_mem && !fault) state_next = S_REQ;
            S_REQ:   if (dmem_gnt) state_next = we_reg ? S_IDLE : S_RESP;
            S_RESP:  if (dmem_rvalid) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ex_ready = (state_reg == S_IDLE);
        dmem_req = (state_reg == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg         <= '0;
            funct3_reg       <= '0;
            rd_reg           <= '0;
            reg_write_reg    <= 1'b0;
            we_reg           <= 1'b0;
            dmem_addr_reg    <= '0;
            dmem_be_reg      <= '0;
            dmem_wdata_reg   <= '0;
            wb_valid_reg     <= 1'b0;
            wb_rd_reg        <= '0;
            wb_data_reg      <= '0;
            wb_reg_write_reg <= 1'b0;
            wb_fault_reg     <= 1'b0;
        end else begin
            wb_valid_reg <= 1'b0;
            if (accept) begin
                addr_reg      <= ex_alu_out;
                funct3_reg    <= ex_funct3;
                rd_reg        <= ex_rd;
                reg_write_reg <= ex_reg_write;
                if (!is_mem || fault) begin
                    wb_valid_reg     <= 1'b1;
                    wb_rd_reg        <= ex_rd;
                    wb_data_reg      <= ex_alu_out;
                    wb_reg_write_reg <= ex_reg_write && !fault;
                    wb_fault_reg     <= fault;
                end else begin
                    we_reg         <= ex_mem_write;
                    dmem_addr_reg  <= {ex_alu_out[WIDTH-1:2], 2'b00};
                    dmem_be_reg    <= lane_be(ex_funct3, ex_alu_out[1:0]);
                    dmem_wdata_reg <= store_lanes(ex_funct3, ex_store_data);
                end
            end
            // Stores retire on grant; loads retire on read data.
            if (state_reg == S_REQ && dmem_gnt && we_reg) begin
                wb_valid_reg     <= 1'b1;
                wb_rd_reg        <= rd_reg;
                wb_data_reg      <= addr_reg;
                wb_reg_write_reg <= 1'b0;
                wb_fault_reg     <= 1'b0;
            end
            if (state_reg == S_RESP && dmem_rvalid) begin
                wb_valid_reg     <= 1'b1;
                wb_rd_reg        <= rd_reg;
                wb_data_reg      <= load_value;
                wb_reg_write_reg <= reg_write_reg;
                wb_fault_reg     <= 1'b0;
            end
        end
    end

    assign dmem_we      = we_reg;
    assign dmem_addr    = dmem_addr_reg;
    assign dmem_be      = dmem_be_reg;
    assign dmem_wdata   = dmem_wdata_reg;
    assign wb_valid     = wb_valid_reg;
    assign wb_rd        = wb_rd_reg;
    assign wb_data      = wb_data_reg;
    assign wb_reg_write = wb_reg_write_reg;
    assign wb_fault     = wb_fault_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: pass-through, stores, aligned loads,
// faults and reset during an outstanding load, with hand-computed expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_store_data;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic        wb_fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_alu_out    (ex_alu_out),
        .ex_store_data (ex_store_data),
        .ex_funct3     (ex_funct3),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_reg_write  (wb_reg_write),
        .wb_fault      (wb_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input logic rw);
        ex_valid      = 1'b1;
        ex_mem_read   = rd_op;
        ex_mem_write  = wr_op;
        ex_funct3     = f3;
        ex_alu_out    = addr;
        ex_store_data = sdata;
        ex_rd         = rd;
        ex_reg_write  = rw;
        tick();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        issue(1'b1, 1'b0, f3, addr, 32'h0, 5'd9, 1'b1);
        chk({tag, "_req"}, {31'b0, dmem_req}, 32'd1);
        chk({tag, "_we"}, {31'b0, dmem_we}, 32'd0);
        chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk({tag, "_req_drop"}, {31'b0, dmem_req}, 32'd0);
        chk({tag, "_no_early_wb"}, {31'b0, wb_valid}, 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        tick();
        dmem_rvalid = 1'b0;
        chk({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd1);
        chk({tag, "_wb_data"}, wb_data, exp);
        chk({tag, "_wb_rd"}, {27'b0, wb_rd}, 32'd9);
        chk({tag, "_wb_rw"}, {31'b0, wb_reg_write}, 32'd1);
        tick();
        chk({tag, "_wb_pulse"}, {31'b0, wb_valid}, 32'd0);
        $display("load %s addr=%h rdata=%h wb_data=%h", tag, addr, rdata, wb_data);
    endtask

    task automatic do_fault(input string tag, input logic rd_op, input logic wr_op,
                            input logic [2:0] f3, input logic [31:0] addr);
        issue(rd_op, wr_op, f3, addr, 32'h55667788, 5'd3, 1'b1);
        chk({tag, "_req"}, {31'b0, dmem_req}, 32'd0);
        chk({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd1);
        chk({tag, "_fault"}, {31'b0, wb_fault}, 32'd1);
        chk({tag, "_rw"}, {31'b0, wb_reg_write}, 32'd0);
        chk({tag, "_data"}, wb_data, addr);
        chk({tag, "_ready"}, {31'b0, ex_ready}, 32'd1);
        $display("fault %s addr=%h wb_fault=%b", tag, addr, wb_fault);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b1; ex_alu_out = 32'hFFFF_FFFF; ex_store_data = '0;
        ex_funct3 = '0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_rd = 5'd1;
        ex_reg_write = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        tick();
        tick();
        ex_valid = 1'b0;
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be", {28'b0, dmem_be}, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_ready", {31'b0, ex_ready}, 32'd1);
        $display("reset wb_valid=%b dmem_req=%b", wb_valid, dmem_req);
        rst_n = 1'b1;
        tick();

        // Pass-through, back to back
        ex_valid = 1'b1; ex_alu_out = 32'h0000_1234; ex_rd = 5'd5; ex_reg_write = 1'b1;
        tick();
        chk("pt_valid", {31'b0, wb_valid}, 32'd1);
        chk("pt_data", wb_data, 32'h0000_1234);
        chk("pt_rd", {27'b0, wb_rd}, 32'd5);
        chk("pt_rw", {31'b0, wb_reg_write}, 32'd1);
        chk("pt_fault", {31'b0, wb_fault}, 32'd0);
        chk("pt_req", {31'b0, dmem_req}, 32'd0);
        $display("pass wb_data=%h", wb_data);
        ex_alu_out = 32'h0000_5678; ex_rd = 5'd6;
        tick();
        chk("pt2_valid", {31'b0, wb_valid}, 32'd1);
        chk("pt2_data", wb_data, 32'h0000_5678);
        chk("pt2_rd", {27'b0, wb_rd}, 32'd6);
        $display("pass wb_data=%h", wb_data);
        ex_valid = 1'b0;
        tick();
        chk("pt_idle", {31'b0, wb_valid}, 32'd0);

        // SB with grant withheld two cycles
        issue(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 5'd7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("sb_req", {31'b0, dmem_req}, 32'd1);
            chk("sb_we", {31'b0, dmem_we}, 32'd1);
            chk("sb_addr", dmem_addr, 32'h0000_1000);
            chk("sb_be", {28'b0, dmem_be}, 32'h8);
            chk("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
            chk("sb_ready", {31'b0, ex_ready}, 32'd0);
            chk("sb_no_wb", {31'b0, wb_valid}, 32'd0);
            if (i == 2) dmem_gnt = 1'b1;
            tick();
        end
        dmem_gnt = 1'b0;
        chk("sb_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("sb_wb_rw", {31'b0, wb_reg_write}, 32'd0);
        chk("sb_wb_fault", {31'b0, wb_fault}, 32'd0);
        chk("sb_req_drop", {31'b0, dmem_req}, 32'd0);
        chk("sb_ready_back", {31'b0, ex_ready}, 32'd1);
        $display("store SB be=%b wdata=%h", dmem_be, dmem_wdata);
        tick();
        chk("sb_wb_pulse", {31'b0, wb_valid}, 32'd0);

        // SH at offset 2
        issue(1'b0, 1'b1, 3'd1, 32'h0000_1002, 32'h1122_3344, 5'd7, 1'b0);
        chk("sh_be", {28'b0, dmem_be}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'h3344_3344);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("sh_wb_valid", {31'b0, wb_valid}, 32'd1);
        $display("store SH be=%b wdata=%h", dmem_be, dmem_wdata);

        do_load("lb",  3'd0, 32'h0000_2002, 32'h1280_3456, 32'hFFFF_FF80);
        do_load("lbu", 3'd4, 32'h0000_2002, 32'h1280_3456, 32'h0000_0080);
        do_load("lh",  3'd1, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001);
        do_load("lhu", 3'd5, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001);
        do_load("lw",  3'd2, 32'h0000_2000, 32'hCAFE_F00D, 32'hCAFE_F00D);

        do_fault("f_lw_mis", 1'b1, 1'b0, 3'd2, 32'h0000_3001);
        do_fault("f_sh_mis", 1'b0, 1'b1, 3'd1, 32'h0000_3003);
        do_fault("f_ld_f3",  1'b1, 1'b0, 3'd3, 32'h0000_3000);
        do_fault("f_rw_both", 1'b1, 1'b1, 3'd2, 32'h0000_3000);

        // Reset while a load waits for read data
        issue(1'b1, 1'b0, 3'd2, 32'h0000_2000, 32'h0, 5'd4, 1'b1);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("rl_ready_busy", {31'b0, ex_ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        chk("rl_req", {31'b0, dmem_req}, 32'd0);
        chk("rl_wb", {31'b0, wb_valid}, 32'd0);
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        tick();
        dmem_rvalid = 1'b0;
        chk("rl_late_rvalid", {31'b0, wb_valid}, 32'd0);
        tick();
        chk("rl_wb_after", {31'b0, wb_valid}, 32'd0);
        chk("rl_ready", {31'b0, ex_ready}, 32'd1);
        $display("reset-mid-load ex_ready=%b wb_valid=%b", ex_ready, wb_valid);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
